fmul_issue: RTL

FMUL_ISSUE -- requirements
Module: fmul_issue

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fmul_rsp_fifo.sv | 67 ++++++
 rtl/fmul_issue.sv | 109 ++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: multiplier latency and the result record carried
// from the multiplier back to the issue logic.
package fpu_pkg;

  localparam int unsigned FP_W       = 32;
  localparam int unsigned FMUL_LAT   = 3;
  // Tag field of the buffered result; requesters must not use wider tags.
  localparam int unsigned FMUL_TAG_W = 5;

  typedef struct packed {
    logic [FMUL_TAG_W-1:0] tag;
    logic [FP_W-1:0]       y;
  } fmul_rsp_t;

endpackage

// File: rtl/fmul_rsp_fifo.sv
// Circular result buffer for fmul_issue. Push and pop may both occur in
// one cycle, including when full; the caller prevents overflow.
module fmul_rsp_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  fmul_rsp_t push_data,
  input  logic      pop,
  output fmul_rsp_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fmul_rsp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != '0);
    if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is data-only; validity comes from the counter
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fmul_issue.sv
// Issue/return wrapper for an external pipelined fmul: tracks in-flight
// requests by tag, buffers results in order and applies credit backpressure.
module fmul_issue
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned LAT   = FMUL_LAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FP_W-1:0]  req_x1,
  input  logic [FP_W-1:0]  req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [FP_W-1:0]  fmul_x1,
  output logic [FP_W-1:0]  fmul_x2,
  input  logic [FP_W-1:0]  fmul_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [FP_W-1:0]  rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                       accept;
  logic                       handoff;
  logic [LAT-1:0]             vld_q;
  logic [LAT-1:0][TAG_W-1:0]  tag_q;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic                       req_ready_q;
  logic                       busy_q;
  logic                       fifo_push;
  logic                       fifo_full;
  logic                       fifo_empty;
  fmul_rsp_t                  fifo_wdata;
  fmul_rsp_t                  fifo_rdata;

  assign fmul_x1 = req_x1;
  assign fmul_x2 = req_x2;

  assign accept  = req_valid && req_ready_q;
  assign handoff = rsp_valid && rsp_ready;

  // Tag/valid shadow of the multiplier pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= req_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Credit guard never blocks in practice; kept so the buffer cannot be overrun
  assign fifo_push  = vld_q[LAT-1] && (!fifo_full || handoff);
  assign fifo_wdata = '{tag: FMUL_TAG_W'(tag_q[LAT-1]), y: fmul_y};

  fmul_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (handoff),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_y     = fifo_rdata.y;
  assign rsp_tag   = TAG_W'(fifo_rdata.tag);

  // Outstanding-request count covers both pipeline and buffer
  always_comb begin
    occ_d = occ_q;
    case ({accept, handoff})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      req_ready_q <= (occ_d < OCC_W'(DEPTH));
      busy_q      <= (occ_d != '0);
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;

endmodule
